// File: rtl/tmr_fault_inject_ctrl.sv
// tmr_fault_inject_ctrl
//   Turns a push-button and core-select switches into single-core fault
//   injections for the TMR demo. Checks that the voter flagged the injected
//   core and counts hits and misses.
// Ports
//   clk, rst_n        : clock, async active-low reset
//   btn_inject_n      : raw active-low button pin (asynchronous)
//   sw_core_sel[1:0]  : raw target-core switches (3 = invalid)
//   fault_flags[2:0]  : voter per-core mismatch flags (clk domain)
//   core_fault_force  : one-hot force to the selected core's corruption mux
//   inject_active     : high while an injection is in progress
//   detect_ok/_miss   : 1-cycle verdict pulse after each injection
//   inject_count      : accepted injections (saturating)
//   miss_count        : injections the voter never flagged (saturating)
module tmr_fault_inject_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned COOLDOWN_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inject_n,
  input  logic [1:0] sw_core_sel,
  input  logic [2:0] fault_flags,
  output logic [2:0] core_fault_force,
  output logic       inject_active,
  output logic       detect_ok,
  output logic       detect_miss,
  output logic [7:0] inject_count,
  output logic [7:0] miss_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PH_MAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INJECT   = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  logic            r_btn_s1, r_btn_s2;
  logic [1:0]      r_sw_s1, r_sw_s2;
  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;

  state_t          r_state;
  logic [PH_W-1:0] r_ph_cnt;
  logic [1:0]      r_tgt;
  logic            r_seen;
  logic [2:0]      r_force;
  logic            r_active;
  logic            r_ok;
  logic            r_miss;
  logic [7:0]      r_inject_count;
  logic [7:0]      r_miss_count;

  logic            w_seen_final;

  // Two-flop synchronizers for the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_sw_s1  <= 2'd0;
      r_sw_s2  <= 2'd0;
    end else begin
      r_btn_s1 <= btn_inject_n;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_core_sel;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce: the synced level must differ from stable for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_btn_s2 == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_btn_s2;
        r_db_cnt <= '0;
        r_press  <= ~r_btn_s2;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Flag seen on the last INJECT cycle still counts toward the verdict
  assign w_seen_final = r_seen | fault_flags[r_tgt];

  // Injection sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ph_cnt       <= '0;
      r_tgt          <= 2'd0;
      r_seen         <= 1'b0;
      r_force        <= 3'b000;
      r_active       <= 1'b0;
      r_ok           <= 1'b0;
      r_miss         <= 1'b0;
      r_inject_count <= 8'd0;
      r_miss_count   <= 8'd0;
    end else begin
      r_ok   <= 1'b0;
      r_miss <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (r_press && (r_sw_s2 != 2'd3)) begin
            r_tgt    <= r_sw_s2;
            r_force  <= 3'b001 << r_sw_s2;
            r_active <= 1'b1;
            r_seen   <= 1'b0;
            r_ph_cnt <= '0;
            r_state  <= ST_INJECT;
            if (r_inject_count != 8'hFF) r_inject_count <= r_inject_count + 8'd1;
          end
        end
        ST_INJECT: begin
          if (r_ph_cnt == PH_W'(HOLD_CYCLES - 1)) begin
            r_force  <= 3'b000;
            r_active <= 1'b0;
            r_ph_cnt <= '0;
            r_state  <= ST_COOLDOWN;
            if (w_seen_final) begin
              r_ok <= 1'b1;
            end else begin
              r_miss <= 1'b1;
              if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
            end
          end else begin
            r_seen   <= w_seen_final;
            r_ph_cnt <= r_ph_cnt + PH_W'(1);
          end
        end
        ST_COOLDOWN: begin
          if (r_ph_cnt == PH_W'(COOLDOWN_CYCLES - 1)) begin
            r_ph_cnt <= '0;
            r_state  <= ST_WAIT_REL;
          end else begin
            r_ph_cnt <= r_ph_cnt + PH_W'(1);
          end
        end
        ST_WAIT_REL: begin
          // A held button must be released before the next injection
          if (r_stable) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_fault_force = r_force;
  assign inject_active    = r_active;
  assign detect_ok        = r_ok;
  assign detect_miss      = r_miss;
  assign inject_count     = r_inject_count;
  assign miss_count       = r_miss_count;

endmodule
